bus_ram: RTL and testbench

// - Synthesizable, parametrised word-addressed RAM slave for the CPU data/instruction bus.
// - Replaces the fixed 1-cycle, 32-bit behavioural memory used around the CPU.
// - Adds byte-lane writes, a valid/ready handshake, programmable read latency and misalignment error reporting.
// - Sits between the CPU bus port and the SoC address decoder; one instance per memory region.

---
 rtl/bus_pkg.sv | 39 +++
 rtl/bus_ram_pipe.sv | 44 ++++
 rtl/bus_ram.sv | 86 ++++++++
 tb/tb_bus_ram.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus encodings, request/response bundles and sizing helpers.
// The struct typedefs describe the default 32-bit CPU bus.
package bus_pkg;

   localparam int BUS_DW = 32;
   localparam int BUS_AW = 32;

   typedef enum logic {
      BUS_READ  = 1'b0,
      BUS_WRITE = 1'b1
   } bus_op_e;

   typedef struct packed {
      logic              valid;
      bus_op_e           we;
      logic [BUS_DW/8-1:0] be;
      logic [BUS_AW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
   } bus_req_t;

   typedef struct packed {
      logic              ready;
      logic              err;
      logic [BUS_DW-1:0] rdata;
   } bus_rsp_t;

   function automatic int lane_count(input int dw);
      return dw / 8;
   endfunction

   function automatic int lane_bits(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int index_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bus_ram_pipe.sv
// LATENCY-deep response delay line {valid, err, data}.
// Stage 0 doubles as the RAM output register; reset flushes every stage.
module bus_ram_pipe
   import bus_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_err,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic             out_err,
   output logic [WIDTH-1:0] out_data
);

   typedef struct packed {
      logic             valid;
      logic             err;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t stg [LATENCY];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= {in_valid, in_err, in_data};
         for (int i = 1; i < LATENCY; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign out_valid = stg[LATENCY-1].valid;
   assign out_err   = stg[LATENCY-1].err;
   assign out_data  = stg[LATENCY-1].data;

endmodule

// File: rtl/bus_ram.sv
// Word-addressed RAM bus slave with byte lanes and fixed read latency.
// Define BUS_RAM_BOUNDS_CHECK_EN to fault accesses outside the region.
module bus_ram
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    busValid,
   input  logic                    busWriteEnable,
   input  logic [DATA_WIDTH/8-1:0] busByteEnable,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   busWriteData,
   output logic [DATA_WIDTH-1:0]   busReadData,
   output logic                    busReady,
   output logic                    busError
);

   localparam int LANES = lane_count(DATA_WIDTH);
   localparam int LB    = lane_bits(DATA_WIDTH);
   localparam int IW    = index_bits(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ADDR_WIDTH'(LANES - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   bus_op_e               op;
   logic [ADDR_WIDTH-1:0] offset;
   logic [IW-1:0]         idx;
   logic                  misaligned;
   logic                  oob;
   logic                  fault;
   logic                  do_write;
   logic [DATA_WIDTH-1:0] rdata;

   assign op         = bus_op_e'(busWriteEnable);
   assign offset     = address - BASE_ADDR;
   assign idx        = offset[LB +: IW];
   assign misaligned = |(offset & ALIGN_MASK);

`ifdef BUS_RAM_BOUNDS_CHECK_EN
   // Below-base addresses wrap to huge offsets, so one compare covers both ends.
   localparam logic [ADDR_WIDTH:0] SPAN =
      (ADDR_WIDTH + 1)'(DEPTH_WORDS * LANES);
   assign oob = ({1'b0, offset} >= SPAN);
`else
   assign oob = 1'b0;
`endif

   assign fault    = misaligned | oob;
   assign do_write = busValid && (op == BUS_WRITE) && !fault;

   // Storage is deliberately outside reset: contents survive a reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int k = 0; k < LANES; k++) begin
            if (busByteEnable[k]) begin
               mem[idx][8*k +: 8] <= busWriteData[8*k +: 8];
            end
         end
      end
   end

   assign rdata = (busValid && op == BUS_READ && !fault)
                ? mem[idx] : '0;

   bus_ram_pipe #(
      .WIDTH   (DATA_WIDTH),
      .LATENCY (LATENCY)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (busValid),
      .in_err    (busValid && fault),
      .in_data   (rdata),
      .out_valid (busReady),
      .out_err   (busError),
      .out_data  (busReadData)
   );

endmodule

// File: tb/tb_bus_ram.sv
// Random + directed bench for bus_ram at latencies 1, 2 and 3.
// A word-array model predicts each response and the cycle it appears.
module tb_bus_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        valid = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   logic        rdy1, err1, rdy2, err2, rdy3, err3;
   logic [31:0] rd1, rd2, rd3;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [33:0] sched [3][4096];
   bit   [31:0] mref [1024];
   int          lat [3] = '{1, 2, 3};

   always #5 clk = ~clk;

   bus_ram #(.LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .busValid(valid),
      .busWriteEnable(we), .busByteEnable(be),
      .address(addr), .busWriteData(wdata),
      .busReadData(rd1), .busReady(rdy1), .busError(err1)
   );

   bus_ram #(.LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .busValid(valid),
      .busWriteEnable(we), .busByteEnable(be),
      .address(addr), .busWriteData(wdata),
      .busReadData(rd2), .busReady(rdy2), .busError(err2)
   );

   bus_ram #(.LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .busValid(valid),
      .busWriteEnable(we), .busByteEnable(be),
      .address(addr), .busWriteData(wdata),
      .busReadData(rd3), .busReady(rdy3), .busError(err3)
   );

   task automatic chk(input string tag, input logic [33:0] obs,
                      input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h",
                tag, cyc, obs, exp);
      end
   endtask

   // Response = {ready, error, data}; the write lands in the model.
   task automatic model(input bit v, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [33:0] r);
      bit      bad;
      int      i;
      bit [31:0] m;
      bad = (a % 4) != 0;
`ifdef BUS_RAM_BOUNDS_CHECK_EN
      if (a >= 32'h1000) bad = 1'b1;
`endif
      i = (a / 4) % 1024;
      if (!v) r = '0;
      else if (bad) r = {2'b11, 32'h0};
      else if (w) begin
         m = '0;
         for (int k = 0; k < 4; k++) if (b[k]) m = m | (32'hFF << (8 * k));
         mref[i] = (mref[i] & ~m) | (d & m);
         r = {2'b10, 32'h0};
      end else r = {2'b10, mref[i]};
   endtask

   task automatic check_all();
      chk("resp_L1", {rdy1, err1, rd1}, sched[0][cyc]);
      chk("resp_L2", {rdy2, err2, rd2}, sched[1][cyc]);
      chk("resp_L3", {rdy3, err3, rd3}, sched[2][cyc]);
   endtask

   task automatic step(input bit v, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
      logic [33:0] r;
      valid = v; we = w; be = b; addr = a; wdata = d;
      model(v, w, b, a, d, r);
      for (int j = 0; j < 3; j++) sched[j][cyc + lat[j] - 1] = r;
      @(posedge clk);
      #1;
      check_all();
      cyc++;
      valid = 1'b0;
   endtask

   task automatic do_reset();
      valid = 1'b0;
      reset = 1'b0;
      #2;
      for (int j = 0; j < 3; j++)
         for (int c = cyc; c < 4096; c++) sched[j][c] = '0;
      chk("rst_L1", {rdy1, err1, rd1}, 34'h0);
      chk("rst_L2", {rdy2, err2, rd2}, 34'h0);
      chk("rst_L3", {rdy3, err3, rd3}, 34'h0);
      @(posedge clk);
      #1;
      check_all();
      cyc++;
      reset = 1'b1;
   endtask

   initial begin
      bit [31:0]   av [4];
      bit          v, w;
      logic [3:0]  b;
      logic [31:0] a;
      int          sel;

      for (int j = 0; j < 3; j++)
         for (int c = 0; c < 4096; c++) sched[j][c] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_L1", {rdy1, err1, rd1}, 34'h0);
      chk("reset_L2", {rdy2, err2, rd2}, 34'h0);
      chk("reset_L3", {rdy3, err3, rd3}, 34'h0);
      reset = 1'b1;

      for (int i = 0; i < 16; i++) step(1, 1, 4'hF, 32'(4 * i), $urandom);

      step(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
      step(1, 0, 4'h0, 32'h10, 32'h0);
      chk("rd_deadbeef", {rdy1, err1, rd1}, 34'h2DEADBEEF);

      step(1, 1, 4'h1, 32'h10, 32'h000000AA);
      step(1, 0, 4'h0, 32'h10, 32'h0);
      chk("rd_lane0", {rdy1, err1, rd1}, 34'h2DEADBEAA);
      step(1, 1, 4'h0, 32'h10, 32'hFFFFFFFF);
      chk("wr_be0_done", {rdy1, err1, rd1}, 34'h200000000);
      step(1, 0, 4'h0, 32'h10, 32'h0);
      chk("rd_after_be0", {rdy1, err1, rd1}, 34'h2DEADBEAA);

      step(1, 0, 4'h0, 32'h12, 32'h0);
      chk("rd_misalign", {rdy1, err1, rd1}, 34'h300000000);
      step(1, 1, 4'hF, 32'h12, 32'hFFFFFFFF);
      chk("wr_misalign", {rdy1, err1, rd1}, 34'h300000000);
      step(1, 0, 4'h0, 32'h10, 32'h0);
      chk("rd_after_mis", {rdy1, err1, rd1}, 34'h2DEADBEAA);

      av = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
      for (int i = 0; i < 4; i++) step(1, 1, 4'hF, 32'(4 * i), av[i]);
      for (int s = 0; s < 8; s++) begin
         step(s < 4, 0, 4'h0, (s < 4) ? 32'(4 * s) : 32'h0, 32'h0);
         if (s >= 2 && s <= 5)
            chk("l3_order", {rdy3, err3, rd3}, {2'b10, av[s-2]});
         else if (s >= 6)
            chk("l3_idle", {rdy3, err3, rd3}, 34'h0);
      end

      step(1, 1, 4'hF, 32'h20, 32'h11111111);
      step(1, 0, 4'h0, 32'h20, 32'h0);
      chk("raw_l1", {rdy1, err1, rd1}, 34'h211111111);
      do_reset();
      chk("flush_l2", {rdy2, err2, rd2}, 34'h0);
      step(1, 0, 4'h0, 32'h20, 32'h0);
      step(0, 0, 4'h0, 32'h0, 32'h0);
      chk("post_rst_l2", {rdy2, err2, rd2}, 34'h211111111);

      step(1, 0, 4'h0, 32'h1000, 32'h0);
`ifdef BUS_RAM_BOUNDS_CHECK_EN
      chk("oob_read", {rdy1, err1, rd1}, 34'h300000000);
`else
      chk("alias_read", {rdy1, err1, rd1}, {2'b10, av[0]});
`endif

      for (int n = 0; n < 400; n++) begin
         v = ($urandom % 4) != 0;
         w = $urandom % 2;
         b = 4'($urandom);
         sel = $urandom % 6;
         a = 32'(4 * ($urandom % 16));
         if (sel == 0) a = a + 32'($urandom_range(1, 3));
         if (sel == 1) a = a + 32'h1000;
         step(v, w, b, a, $urandom);
      end
      for (int n = 0; n < 4; n++) step(0, 0, 4'h0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
